// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
//   Bundles the instruction-register fields, ALU flag and memory handshake
//   consumed by the controller, together with every control output it
//   drives into the datapath.
//   master : controller side (fields/zero/mem_ready in, controls out)
//   slave  : datapath / memory side (the mirror image)
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       alu_src_b;
  logic [3:0] operation;
  logic       retire;
  logic       trap;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
           wb_sel, alu_src_b, operation, retire, trap, state
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
           wb_sel, alu_src_b, operation, retire, trap, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle RV32I control FSM: sequences each instruction through
//   FETCH/DECODE/EXEC/MEM/WB over one variable-latency memory port and
//   generates datapath enables, mux selects and the 4-bit ALU operation.
//   Illegal encodings and a memory port stuck without mem_ready for
//   TIMEOUT consecutive cycles both park the FSM in TRAP until reset.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; all outputs forced to 0 while low
//   bus   : multicycle_controller_if.master (fields in, controls out)
module multicycle_controller #(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  state_t               state_q, state_n;
  logic [TIMEOUT_W-1:0] wait_q, wait_n, wait_inc;

  // instruction class decode
  logic is_r, is_imm, is_load, is_store, is_branch, is_jal, is_lui;
  logic f7_base, f7_alt, is_shift, legal, taken;
  alu_op_t exec_op;

  // unmasked control values; gated by rst_n on the way out
  logic       mem_req_c, mem_we_c, i_or_d_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c, wb_sel_c;
  logic       reg_write_c, alu_src_b_c, retire_c, trap_c;
  logic [3:0] operation_c;
  logic       waiting, timed_out;

  always_comb begin
    is_r      = (bus.opcode == OP_R);
    is_imm    = (bus.opcode == OP_IMM);
    is_load   = (bus.opcode == OP_LOAD);
    is_store  = (bus.opcode == OP_STORE);
    is_branch = (bus.opcode == OP_BRANCH);
    is_jal    = (bus.opcode == OP_JAL);
    is_lui    = (bus.opcode == OP_LUI);

    f7_base   = (bus.funct7 == F7_BASE);
    f7_alt    = (bus.funct7 == F7_ALT);
    is_shift  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);

    // OP-IMM only inspects funct7 for the shifts, and never yields SUB.
    legal = (is_r      && (f7_base || (f7_alt && (bus.funct3 == 3'b000 ||
                                                  bus.funct3 == 3'b101)))) ||
            (is_imm    && (!is_shift || f7_base ||
                           (f7_alt && bus.funct3 == 3'b101)))               ||
            (is_branch && (bus.funct3 == 3'b000 || bus.funct3 == 3'b001))  ||
            is_load || is_store || is_jal || is_lui;

    // BEQ takes on zero, BNE on not-zero
    taken = bus.funct3[0] ? !bus.zero : bus.zero;
  end

  always_comb begin
    exec_op = ALU_ADD;
    if (is_branch) begin
      exec_op = ALU_SUB;
    end else if (is_r || is_imm) begin
      unique case (bus.funct3)
        3'b000: exec_op = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
        3'b001: exec_op = ALU_SLL;
        3'b010: exec_op = ALU_SLT;
        3'b011: exec_op = ALU_SLTU;
        3'b100: exec_op = ALU_XOR;
        3'b101: exec_op = f7_alt ? ALU_SRA : ALU_SRL;
        3'b110: exec_op = ALU_OR;
        3'b111: exec_op = ALU_AND;
        default: exec_op = ALU_ADD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_n;
      wait_q  <= wait_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    i_or_d_c    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'd0;
    reg_write_c = 1'b0;
    wb_sel_c    = 2'd0;
    alu_src_b_c = 1'b0;
    operation_c = ALU_ADD;
    retire_c    = 1'b0;
    trap_c      = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          state_n    = DECODE;
        end
      end
      DECODE: begin
        if (!legal)                state_n = TRAP;
        else if (is_lui || is_jal) state_n = WB;
        else                       state_n = EXEC;
      end
      EXEC: begin
        operation_c = exec_op;
        alu_src_b_c = is_imm || is_load || is_store;
        if (is_branch) begin
          pc_write_c = 1'b1;
          retire_c   = 1'b1;
          pc_src_c   = taken ? 2'd1 : 2'd0;
          state_n    = FETCH;
        end else if (is_load || is_store) begin
          state_n = MEM;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        mem_req_c = 1'b1;
        i_or_d_c  = 1'b1;
        mem_we_c  = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_n    = FETCH;
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        retire_c    = 1'b1;
        if (is_lui)       wb_sel_c = 2'd3;
        else if (is_jal)  wb_sel_c = 2'd2;
        else if (is_load) wb_sel_c = 2'd1;
        else              wb_sel_c = 2'd0;
        pc_src_c = is_jal ? 2'd2 : 2'd0;
        state_n  = FETCH;
      end
      TRAP: begin
        operation_c = '0;
        trap_c      = 1'b1;
      end
      default: begin
        operation_c = '0;
        state_n     = TRAP;
      end
    endcase

    // Ready timeout: the cycle in which the wait count would reach TIMEOUT
    // forces TRAP; a mem_ready in that cycle is not a wait and wins.
    waiting   = mem_req_c && !bus.mem_ready;
    wait_inc  = wait_q + 1'b1;
    timed_out = (TIMEOUT != 0) && waiting &&
                (wait_inc == TIMEOUT_W'(TIMEOUT));
    if (timed_out) state_n = TRAP;

    wait_n = (waiting && (state_n == state_q)) ? wait_inc : '0;
  end

  // Outputs are masked by rst_n so they drop the moment reset asserts,
  // without waiting for the state register to be cleared by an edge.
  assign bus.mem_req   = rst_n & mem_req_c;
  assign bus.mem_we    = rst_n & mem_we_c;
  assign bus.i_or_d    = rst_n & i_or_d_c;
  assign bus.ir_write  = rst_n & ir_write_c;
  assign bus.pc_write  = rst_n & pc_write_c;
  assign bus.pc_src    = rst_n ? pc_src_c    : '0;
  assign bus.reg_write = rst_n & reg_write_c;
  assign bus.wb_sel    = rst_n ? wb_sel_c    : '0;
  assign bus.alu_src_b = rst_n & alu_src_b_c;
  assign bus.operation = rst_n ? operation_c : '0;
  assign bus.retire    = rst_n & retire_c;
  assign bus.trap      = rst_n & trap_c;
  assign bus.state     = rst_n ? state_q     : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Randomised instruction stream with a reactive variable-latency memory.
//   The driver pushes the reference expectation of each instruction into a
//   scoreboard queue; an independent negedge monitor accumulates what the
//   controller does and compares on every retire or trap. Directed sections
//   cover reset, ready timeout and asynchronous reset during a store.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_controller_if bus ();

  multicycle_controller #(.TIMEOUT(15), .TIMEOUT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] BASE_OP [0:7] = '{4'b0010, 4'b0100, 4'b0111, 4'b1001,
                                           4'b0011, 4'b0101, 4'b0001, 4'b0000};
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SRA = 4'b1000;
  localparam logic [3:0] NO_EXEC = 4'hF;

  typedef struct {
    int unsigned idx;
    bit          legal;
    int unsigned cycles;
    logic [3:0]  op;
    bit          srcb;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_src;
    int unsigned rw_cnt;
    int unsigned we_cnt;
  } exp_t;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          z;
    int unsigned fw;
    int unsigned mw;
  } instr_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          mon_en   = 1'b0;
  bit          done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit known_opcode(input logic [6:0] o);
    return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
           o == 7'b0100011 || o == 7'b1100011 || o == 7'b1101111 ||
           o == 7'b0110111;
  endfunction

  // Reference: per-instruction outcome from the ISA rules and latency table.
  function automatic exp_t model(input instr_t s);
    exp_t e;
    e.idx = 0; e.legal = 1'b1; e.op = NO_EXEC; e.srcb = 1'b0;
    e.wb_sel = 2'd0; e.pc_src = 2'd0; e.rw_cnt = 0; e.we_cnt = 0;
    e.cycles = 0;
    case (s.opc)
      7'b0110011: begin
        e.legal  = (s.f7 == 7'h00) || (s.f7 == 7'h20 && (s.f3 == 3'd0 || s.f3 == 3'd5));
        e.op     = (s.f7 == 7'h20) ? ((s.f3 == 3'd0) ? A_SUB : A_SRA) : BASE_OP[s.f3];
        e.rw_cnt = 1; e.cycles = 4 + s.fw;
      end
      7'b0010011: begin
        e.legal  = !(s.f3 == 3'd1 || s.f3 == 3'd5) || (s.f7 == 7'h00) ||
                   (s.f7 == 7'h20 && s.f3 == 3'd5);
        e.op     = (s.f3 == 3'd5 && s.f7 == 7'h20) ? A_SRA : BASE_OP[s.f3];
        e.srcb   = 1'b1; e.rw_cnt = 1; e.cycles = 4 + s.fw;
      end
      7'b0000011: begin
        e.op = A_ADD; e.srcb = 1'b1; e.wb_sel = 2'd1; e.rw_cnt = 1;
        e.cycles = 5 + s.fw + s.mw;
      end
      7'b0100011: begin
        e.op = A_ADD; e.srcb = 1'b1; e.we_cnt = s.mw + 1;
        e.cycles = 4 + s.fw + s.mw;
      end
      7'b1100011: begin
        e.legal  = (s.f3 == 3'd0) || (s.f3 == 3'd1);
        e.op     = A_SUB;
        e.pc_src = ((s.f3 == 3'd0) ? s.z : !s.z) ? 2'd1 : 2'd0;
        e.cycles = 3 + s.fw;
      end
      7'b1101111: begin
        e.wb_sel = 2'd2; e.pc_src = 2'd2; e.rw_cnt = 1; e.cycles = 3 + s.fw;
      end
      7'b0110111: begin
        e.wb_sel = 2'd3; e.rw_cnt = 1; e.cycles = 3 + s.fw;
      end
      default: e.legal = 1'b0;
    endcase
    if (!e.legal) e.cycles = s.fw + 3;
    return e;
  endfunction

  function automatic instr_t pick(input int unsigned i);
    instr_t s;
    logic [6:0] ops [0:6];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111};
    s.f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0, 3:    s.f7 = 7'h00;
      1:       s.f7 = 7'h20;
      default: s.f7 = 7'($urandom_range(0, 127));
    endcase
    s.z  = 1'($urandom_range(0, 1));
    s.fw = $urandom_range(0, 4);
    s.mw = $urandom_range(0, 4);
    if ($urandom_range(0, 9) == 0) begin
      do s.opc = 7'($urandom_range(0, 127)); while (known_opcode(s.opc));
    end else begin
      s.opc = ops[$urandom_range(0, 6)];
    end
    if (s.opc == 7'b1100011 && $urandom_range(0, 3) != 0) s.f3 = 3'($urandom_range(0, 1));
    case (i)
      0: s = '{7'b0110011, 3'b000, 7'h00, 1'b0, 0, 0};  // add x3,x1,x2
      1: s = '{7'b0000011, 3'b010, 7'h00, 1'b0, 3, 3};  // lw, 3 waits each access
      2: s = '{7'b1100011, 3'b000, 7'h00, 1'b1, 0, 0};  // beq, zero=1
      3: s = '{7'b1100011, 3'b001, 7'h00, 1'b1, 0, 0};  // bne, zero=1
      4: s = '{7'b0110011, 3'b000, 7'h20, 1'b0, 1, 0};  // sub
      5: s = '{7'b0010011, 3'b101, 7'h20, 1'b0, 0, 0};  // srai
      6: s = '{7'b0110011, 3'b100, 7'h20, 1'b0, 0, 0};  // illegal R
      default: ;
    endcase
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Drives one instruction with a reactive memory; returns when the
  // monitor has seen it retire or trap.
  task automatic run_instr(input int unsigned i);
    instr_t      s;
    exp_t        e;
    int          acc[$];
    int          cur;
    int unsigned budget;
    s = pick(i);
    e = model(s);
    e.idx = i;
    sb.push_back(e);
    bus.opcode = s.opc; bus.funct3 = s.f3; bus.funct7 = s.f7; bus.zero = s.z;
    acc.push_back(int'(s.fw));
    if (s.opc == 7'b0000011 || s.opc == 7'b0100011) acc.push_back(int'(s.mw));
    cur = -1;
    budget = 0;
    done = 1'b0;
    forever begin
      if (bus.mem_req) begin
        if (cur < 0) cur = (acc.size() != 0) ? acc.pop_front() : 0;
        if (cur == 0) begin bus.mem_ready = 1'b1; cur = -1; end
        else begin bus.mem_ready = 1'b0; cur--; end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (done) break;
      budget++;
      if (budget > 60) begin
        n_checks++; n_fail++;
        $display("FAIL i%0d_budget: no retire or trap within %0d cycles", i, budget);
        break;
      end
    end
    if (bus.trap || budget > 60) begin
      do_reset();
      sb.delete();
    end
  endtask

  // ---------------- monitor ----------------
  int unsigned cyc, rw, we, pcw, irw;
  logic [3:0]  op_exec;
  bit          srcb_exec, bad_add, rw_bad, iod_bad, trap_seen;

  function automatic logic [15:0] ctl_word();
    return {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
            bus.pc_src, bus.reg_write, bus.wb_sel, bus.alu_src_b,
            bus.operation, bus.retire};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      cyc = 0; rw = 0; we = 0; pcw = 0; irw = 0; op_exec = NO_EXEC;
      srcb_exec = 0; bad_add = 0; rw_bad = 0; iod_bad = 0; trap_seen = 0;
    end else if (!trap_seen) begin
      cyc++;
      if (bus.trap) begin
        trap_seen = 1'b1;
        done = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_trap", 32'(bus.trap), 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("i%0d_trap", e.idx), 32'(bus.trap), 32'(!e.legal));
          check($sformatf("i%0d_trap_cycles", e.idx), cyc, e.cycles);
          check($sformatf("i%0d_trap_state", e.idx), 32'(bus.state), 32'd7);
          check($sformatf("i%0d_trap_outputs", e.idx), 32'(ctl_word()), 32'd0);
        end
      end else begin
        if (bus.state == 3'd2) begin
          op_exec = bus.operation; srcb_exec = bus.alu_src_b;
        end else if (bus.operation != A_ADD) begin
          bad_add = 1'b1;
        end
        if (bus.reg_write) begin rw++; if (bus.state != 3'd4) rw_bad = 1'b1; end
        if (bus.mem_req && bus.mem_we) we++;
        if (bus.pc_write) pcw++;
        if (bus.ir_write) irw++;
        if (bus.state == 3'd3 && !(bus.mem_req && bus.i_or_d)) iod_bad = 1'b1;
        if (bus.retire) begin
          done = 1'b1;
          if (sb.size() == 0) begin
            check("unexpected_retire", 32'(bus.retire), 32'd0);
          end else begin
            e = sb.pop_front();
            check($sformatf("i%0d_no_trap", e.idx), 32'(bus.trap), 32'(!e.legal));
            check($sformatf("i%0d_cycles", e.idx), cyc, e.cycles);
            check($sformatf("i%0d_exec_op", e.idx), 32'(op_exec), 32'(e.op));
            check($sformatf("i%0d_alu_src_b", e.idx), 32'(srcb_exec), 32'(e.srcb));
            check($sformatf("i%0d_wb_sel", e.idx), 32'(bus.wb_sel), 32'(e.wb_sel));
            check($sformatf("i%0d_pc_src", e.idx), 32'(bus.pc_src), 32'(e.pc_src));
            check($sformatf("i%0d_reg_write_cnt", e.idx), rw, e.rw_cnt);
            check($sformatf("i%0d_mem_we_cnt", e.idx), we, e.we_cnt);
            check($sformatf("i%0d_pc_write_cnt", e.idx), pcw, 32'd1);
            check($sformatf("i%0d_ir_write_cnt", e.idx), irw, 32'd1);
            check($sformatf("i%0d_op_add_outside_exec", e.idx), 32'(bad_add), 32'd0);
            check($sformatf("i%0d_reg_write_outside_wb", e.idx), 32'(rw_bad), 32'd0);
            check($sformatf("i%0d_mem_addr_sel", e.idx), 32'(iod_bad), 32'd0);
          end
          cyc = 0; rw = 0; we = 0; pcw = 0; irw = 0; op_exec = NO_EXEC;
          srcb_exec = 0; bad_add = 0; rw_bad = 0; iod_bad = 0;
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0; bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    check("reset_outputs", 32'({ctl_word(), bus.trap, bus.state}), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("release_fetch", 32'({bus.state, bus.mem_req, bus.i_or_d}), 32'b000_1_0);
    mon_en = 1'b1;

    for (int unsigned i = 0; i < 150; i++) run_instr(i);
    mon_en = 1'b0;
    check("scoreboard_drained", sb.size(), 32'd0);

    // ready timeout in FETCH: trap right after the 15th wait cycle
    do_reset();
    bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7 = 7'h00;
    for (int k = 1; k < 15; k++) begin @(posedge clk); #1; end
    check("timeout_cycle15_no_trap", 32'({bus.trap, bus.state, bus.mem_req}), 32'b0_000_1);
    @(posedge clk); #1;
    check("timeout_trap", 32'({bus.trap, bus.state, bus.mem_req}), 32'b1_111_0);
    for (int k = 0; k < 3; k++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("trap_sticky", 32'({bus.trap, bus.state}), 32'b1_111);
    check("trap_outputs_zero", 32'(ctl_word()), 32'd0);

    // mem_ready in the would-be timeout cycle wins
    do_reset();
    for (int k = 1; k < 15; k++) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b1;
    #1;
    check("late_ready_ir_write", 32'(bus.ir_write), 32'd1);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    check("late_ready_no_trap", 32'({bus.trap, bus.state}), 32'b0_001);

    // asynchronous reset during MEM of a store
    do_reset();
    bus.opcode = 7'b0100011; bus.funct3 = 3'b010; bus.funct7 = 7'h00;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    #1;
    check("store_mem", 32'({bus.state, bus.mem_req, bus.mem_we, bus.i_or_d}), 32'b011_1_1_1);
    #1 rst_n = 1'b0;
    #1;
    check("store_async_reset", 32'({bus.state, bus.mem_req, bus.mem_we, bus.trap}), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("store_restart", 32'({bus.state, bus.mem_req, bus.i_or_d, bus.trap}), 32'b000_1_0_0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle RISC-V control path: one FSM sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB over a shared, variable-latency memory port, and generates datapath enables, mux selects and the 4-bit ALU operation. It sits between the instruction register (opcode/funct fields) and a multi-cycle datapath with a single memory interface. A parametrised ready-timeout and an illegal-instruction trap are new relative to the single-cycle controller.

## Interface
- TIMEOUT, 15, max consecutive cycles with mem_req=1 and mem_ready=0 before trapping; 0 disables the timeout.
- TIMEOUT_W, 4, width of the wait counter; must satisfy TIMEOUT < 2^TIMEOUT_W.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction register bits [6:0].
- funct3  in  3  instruction register bits [14:12].
- funct7  in  7  instruction register bits [31:25].
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_we  out  1  write strobe; meaningful only with mem_req.
- i_or_d  out  1  address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC this cycle.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = JAL target.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = U-immediate.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- operation  out  4  ALU operation.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- trap  out  1  sticky fault indicator.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.

## Operation
- Opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111. Any other opcode → TRAP from DECODE.
- ALU encoding by funct3: 000 ADD 0010 / SUB 0110, 001 SLL 0100, 010 SLT 0111, 011 SLTU 1001, 100 XOR 0011, 101 SRL 0101 / SRA 1000, 110 OR 0001, 111 AND 0000.
- R-type: funct7 0000000 selects the base op. funct7 0100000 is legal only for funct3 000 (SUB) and 101 (SRA). Other funct7 values → TRAP.
- OP-IMM: funct7 is ignored except for 001/101; for those it follows the R rules (SUB never generated). alu_src_b=1.
- LOAD/STORE use ADD with alu_src_b=1. BRANCH uses SUB with alu_src_b=0.
- operation = ADD in every state except EXEC.
- Sequences: ALU ops F-D-E-WB(wb_sel 0); LUI F-D-WB(wb_sel 3); JAL F-D-WB(wb_sel 2, pc_src 2); LOAD F-D-E-MEM-WB(wb_sel 1); STORE F-D-E-MEM; BRANCH F-D-E.
- Branch: only BEQ (000, taken if zero=1) and BNE (001, taken if zero=0) are legal. pc_src = taken ? 1 : 0. Other funct3 values → TRAP from DECODE.
- The final state of each instruction asserts pc_write and retire, then returns to FETCH. reg_write is asserted only in WB.
- TRAP: all outputs 0 except trap=1 and state=7. Exit only by reset.

## Timing
- While rst_n=0: state=FETCH, wait counter=0, every output 0 (including mem_req). First cycle after release: FETCH with mem_req=1, i_or_d=0.
- Async reset mid-instruction aborts immediately. mem_req drops in the same cycle as rst_n falls, without waiting for a clock edge.
- FETCH: mem_req held until mem_ready. ir_write is asserted combinationally in the mem_ready cycle, then → DECODE.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for STORE. A store asserts pc_write/retire in its mem_ready cycle. A load goes → WB on mem_ready.
- mem_ready is ignored when mem_req=0.
- Wait counter: increments each cycle with mem_req=1 and mem_ready=0, and clears on mem_ready or state change. Reaching TIMEOUT (≠0) → TRAP at the next edge. mem_ready arriving in that same cycle wins and no trap occurs.
- Zero-wait latencies: BRANCH 3 cycles, LUI/JAL 3, ALU 4, STORE 4, LOAD 5. Each wait cycle adds one.

## Test plan
- Reset released, mem_ready=1 always, instr add (0x002081B3) → states 0,1,2,4; operation=0010 in EXEC; reg_write=1, wb_sel=0, pc_write=1 and retire=1 in WB; next FETCH on cycle 5.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM → 11 total cycles; mem_we=0; i_or_d=1 in MEM; wb_sel=1 in WB.
- BEQ with zero=1 → pc_src=1 and pc_write=1 in EXEC. BNE with zero=1 → pc_src=0. Both retire at cycle 3.
- SUB (funct7 0100000, funct3 000) → 0110; SRAI → 1000; R-type funct7 0100000 with funct3 100 → trap=1 after DECODE, outputs frozen at 0.
- TIMEOUT=15, mem_ready held 0 in FETCH → trap=1 after the 15th wait cycle. Repeat with mem_ready=1 in that same cycle → no trap.
- rst_n pulsed low during MEM of a store → mem_req and mem_we drop asynchronously; after release, FETCH restarts with trap=0.
